decoder_ctrl: RTL and testbench
===============================

DECODER_CTRL -- requirements
Module: decoder_ctrl

Interface
REQ-001 Parameter TB_DEPTH, default `TRACEBACK_DEPTH, trellis steps per frame and traceback length.
REQ-002 Parameter WD_MARGIN, default 4, extra traceback cycles allowed before timeout.
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 i_start  in  1  frame request, sampled in IDLE only.
REQ-006 i_sym_num  in  7  trellis steps in frame, latched on accepted i_start.
REQ-007 i_sym_valid  in  1  input buffer holds a symbol.
REQ-008 i_tb_done  in  1  traceback completion flag.
REQ-009 i_abort  in  1  cancel current frame.
REQ-010 o_sym_ready  out  1  symbol accepted when high with i_sym_valid.
REQ-011 o_en_acs  out  1  ACS/path-metric update enable.
REQ-012 o_acs_clr  out  1  path-metric clear pulse.
REQ-013 o_en_sel  out  1  minimum-metric node select enable.
REQ-014 o_tb_rst_n  out  1  active-low reset to traceback stage.
REQ-015 o_en_t  out  1  traceback enable.
REQ-016 o_busy, o_done, o_err  out  1 each  status; o_done, o_err single-cycle pulses.
REQ-017 o_sym_cnt  out  7  accepted symbols this frame; o_state  out  3  FSM encoding.

Function
REQ-018 States IDLE, CLR, ACS, SEL, TB, DONE; all outputs registered.
REQ-019 IDLE: i_start=1 and 1<=i_sym_num<=TB_DEPTH -> CLR, latch i_sym_num, o_sym_cnt<=0.
REQ-020 IDLE: i_start=1 with i_sym_num=0 or >TB_DEPTH -> o_err pulse, stay IDLE.
REQ-021 CLR: exactly one cycle; o_acs_clr=1, o_tb_rst_n=0; -> ACS.
REQ-022 ACS: o_sym_ready=1; o_en_acs=1 only in cycles where i_sym_valid=1; o_sym_cnt increments per accept.
REQ-023 ACS: accept with o_sym_cnt==latched_num-1 -> SEL; o_sym_cnt saturates at latched_num.
REQ-024 ACS with i_sym_valid=0 holds indefinitely; no timeout.
REQ-025 SEL: exactly one cycle o_en_sel=1, o_en_t=0 so traceback loads selected node; -> TB.
REQ-026 TB: o_en_t=1 each cycle until i_tb_done=1, then -> DONE with o_en_t=0 next cycle.
REQ-027 TB: cycle counter exceeds TB_DEPTH+WD_MARGIN without i_tb_done -> o_err pulse, -> IDLE.
REQ-028 DONE: o_done=1 one cycle, o_busy=0 thereafter; -> IDLE.
REQ-029 o_busy=1 in every state except IDLE.
REQ-030 i_abort=1 in CLR/ACS/SEL/TB -> IDLE next cycle, enables low, no o_done, o_tb_rst_n=0 one cycle.
REQ-031 i_abort in IDLE or DONE ignored; i_abort and i_tb_done together: abort wins.
REQ-032 i_start while busy ignored; no queuing.
REQ-033 o_en_acs, o_en_sel, o_en_t mutually exclusive every cycle.

Reset
REQ-034 rst=1 -> IDLE; o_tb_rst_n=0, all other outputs 0, counters and latched_num 0.
REQ-035 rst mid-frame overrides i_abort and all inputs; no o_done, no o_err.
REQ-036 o_tb_rst_n returns to 1 first cycle after rst deasserts.

Structure
REQ-037 State enum and TB_DEPTH/WD_MARGIN defaults in shared package alongside param_def macros.
REQ-038 Single module; watchdog counter inline, no sub-modules.

Verification
REQ-039 i_sym_num=8, i_sym_valid=1 continuous, i_tb_done 8 cycles after o_en_t -> 8 o_en_acs cycles, 1 o_en_sel, o_done 1 cycle after i_tb_done.
REQ-040 i_sym_num=4, i_sym_valid toggling 1010... -> exactly 4 o_en_acs cycles over 8 ACS cycles, o_sym_cnt=4.
REQ-041 i_sym_num=0 and i_sym_num=TB_DEPTH+1 -> o_err pulse, o_busy stays 0.
REQ-042 i_tb_done never asserted -> o_err after TB_DEPTH+WD_MARGIN+1 TB cycles, IDLE, no o_done.
REQ-043 i_abort during ACS after 3 accepts -> IDLE next cycle, o_tb_rst_n low 1 cycle, no o_done; new i_start then completes.
REQ-044 rst asserted in TB -> all outputs reset next cycle, o_tb_rst_n=0, state IDLE.

Source files
------------

// File: rtl/decoder_ctrl_pkg.sv
// Shared definitions for the Viterbi decoder frame controller: FSM state
// encoding, bus widths and default traceback sizing.
`ifndef TRACEBACK_DEPTH
`define TRACEBACK_DEPTH 64
`endif

package decoder_ctrl_pkg;

   // Trellis steps per frame / traceback length, and watchdog slack.
   localparam int TB_DEPTH_DEF  = `TRACEBACK_DEPTH;
   localparam int WD_MARGIN_DEF = 4;

   localparam int SYM_W   = 7;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      ACS  = 3'd2,
      SEL  = 3'd3,
      TB   = 3'd4,
      DONE = 3'd5
   } state_t;

endpackage

// File: rtl/decoder_ctrl_if.sv
// Handshake and status bundle between the frame sequencer and the
// decoder datapath / host. The controller sits on the slave side.
interface decoder_ctrl_if;
   import decoder_ctrl_pkg::*;

   logic               i_start;
   logic [SYM_W-1:0]   i_sym_num;
   logic               i_sym_valid;
   logic               i_tb_done;
   logic               i_abort;

   logic               o_sym_ready;
   logic               o_en_acs;
   logic               o_acs_clr;
   logic               o_en_sel;
   logic               o_tb_rst_n;
   logic               o_en_t;
   logic               o_busy;
   logic               o_done;
   logic               o_err;
   logic [SYM_W-1:0]   o_sym_cnt;
   logic [STATE_W-1:0] o_state;

   modport master (
      output i_start, i_sym_num, i_sym_valid, i_tb_done, i_abort,
      input  o_sym_ready, o_en_acs, o_acs_clr, o_en_sel, o_tb_rst_n, o_en_t,
             o_busy, o_done, o_err, o_sym_cnt, o_state
   );

   modport slave (
      input  i_start, i_sym_num, i_sym_valid, i_tb_done, i_abort,
      output o_sym_ready, o_en_acs, o_acs_clr, o_en_sel, o_tb_rst_n, o_en_t,
             o_busy, o_done, o_err, o_sym_cnt, o_state
   );

endinterface

// File: rtl/decoder_ctrl.sv
// Frame sequencer for a Viterbi decoder: clears path metrics, gates ACS
// updates per accepted symbol, triggers min-metric select, then runs the
// traceback under a watchdog. Every output is a register. State-derived
// outputs line up with the state they describe; the datapath enables are
// one-cycle strobes following the cycle that earned them, which keeps
// them mutually exclusive across state changes.
module decoder_ctrl
   import decoder_ctrl_pkg::*;
#(
   parameter int TB_DEPTH  = TB_DEPTH_DEF,
   parameter int WD_MARGIN = WD_MARGIN_DEF
) (
   input  logic          clk,
   input  logic          rst,
   decoder_ctrl_if.slave bus
);

   localparam int WD_LIMIT = TB_DEPTH + WD_MARGIN;
   localparam int WD_W     = $clog2(WD_LIMIT + 1);

   localparam logic [SYM_W:0]  TB_DEPTH_L = (SYM_W+1)'(TB_DEPTH);
   localparam logic [WD_W-1:0] WD_LIMIT_L = WD_W'(WD_LIMIT);

   state_t           state, state_nxt;
   logic [SYM_W-1:0] num_q, num_nxt;
   logic [SYM_W-1:0] cnt_q, cnt_nxt;
   logic [WD_W-1:0]  wd_q, wd_nxt;

   logic en_acs_nxt, en_sel_nxt, en_t_nxt, err_nxt, flush;
   logic start_ok;

   logic sym_ready_q, en_acs_q, acs_clr_q, en_sel_q, tb_rst_n_q, en_t_q;
   logic busy_q, done_q, err_q;

   assign start_ok = (bus.i_sym_num != '0) && ({1'b0, bus.i_sym_num} <= TB_DEPTH_L);

   // Next-state, counter and strobe decode; abort pre-empts every other
   // event in the active states, and a flush pulses the traceback reset.
   always_comb begin
      state_nxt  = state;
      num_nxt    = num_q;
      cnt_nxt    = cnt_q;
      wd_nxt     = wd_q;
      en_acs_nxt = 1'b0;
      en_sel_nxt = 1'b0;
      en_t_nxt   = 1'b0;
      err_nxt    = 1'b0;
      flush      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_start) begin
               if (start_ok) begin
                  state_nxt = CLR;
                  num_nxt   = bus.i_sym_num;
                  cnt_nxt   = '0;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         CLR: begin
            if (bus.i_abort) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else begin
               state_nxt = ACS;
            end
         end
         ACS: begin
            if (bus.i_abort) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else if (bus.i_sym_valid) begin
               en_acs_nxt = 1'b1;
               if (cnt_q < num_q) cnt_nxt = cnt_q + SYM_W'(1);
               if (cnt_q == num_q - SYM_W'(1)) state_nxt = SEL;
            end
         end
         SEL: begin
            if (bus.i_abort) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else begin
               en_sel_nxt = 1'b1;
               wd_nxt     = '0;
               state_nxt  = TB;
            end
         end
         TB: begin
            if (bus.i_abort) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else if (bus.i_tb_done) begin
               state_nxt = DONE;
            end else if (wd_q == WD_LIMIT_L) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
               flush     = 1'b1;
            end else begin
               en_t_nxt = 1'b1;
               wd_nxt   = wd_q + WD_W'(1);
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, counters and all output registers; reset parks the traceback in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         num_q       <= '0;
         cnt_q       <= '0;
         wd_q        <= '0;
         sym_ready_q <= 1'b0;
         en_acs_q    <= 1'b0;
         acs_clr_q   <= 1'b0;
         en_sel_q    <= 1'b0;
         tb_rst_n_q  <= 1'b0;
         en_t_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         num_q       <= num_nxt;
         cnt_q       <= cnt_nxt;
         wd_q        <= wd_nxt;
         sym_ready_q <= (state_nxt == ACS);
         en_acs_q    <= en_acs_nxt;
         acs_clr_q   <= (state_nxt == CLR);
         en_sel_q    <= en_sel_nxt;
         tb_rst_n_q  <= !(flush || (state_nxt == CLR));
         en_t_q      <= en_t_nxt;
         busy_q      <= (state_nxt != IDLE);
         done_q      <= (state_nxt == DONE);
         err_q       <= err_nxt;
      end
   end

   assign bus.o_sym_ready = sym_ready_q;
   assign bus.o_en_acs    = en_acs_q;
   assign bus.o_acs_clr   = acs_clr_q;
   assign bus.o_en_sel    = en_sel_q;
   assign bus.o_tb_rst_n  = tb_rst_n_q;
   assign bus.o_en_t      = en_t_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_err       = err_q;
   assign bus.o_sym_cnt   = cnt_q;
   assign bus.o_state     = state;

endmodule

// File: tb/tb_decoder_ctrl.sv
// Scoreboard bench for decoder_ctrl: each directed scenario pushes its
// hand-computed frame summary; the monitor tallies enables and states per
// frame and compares when the frame ends (busy falls) or a start is rejected.
module tb_decoder_ctrl;
   import decoder_ctrl_pkg::*;

   typedef struct {
      int kind;    // 0 = frame end, 1 = rejected start
      int done;
      int err;
      int acs;
      int sel;
      int t;
      int tbcyc;
      int acscyc;
      int sym;
      int tbrst;   // -1 = don't care
   } exp_rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   decoder_ctrl_if bus();

   decoder_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_rec_t sb_q[$];
   int n_pass  = 0;
   int n_total = 0;

   int  m_acs, m_sel, m_t, m_tbcyc, m_acscyc, m_done, m_excl;
   logic prev_busy    = 1'b0;
   logic post_pending = 1'b0;
   logic post_reject  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      if (exp < 0) return;
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic bound_fail(input string name);
      n_total++;
      $display("FAIL %s: wait bound expired, got timeout, expected event", name);
   endtask

   task automatic push(input int kind, input int done, input int err, input int acs,
                       input int sel, input int t, input int tbcyc, input int acscyc,
                       input int sym, input int tbrst);
      exp_rec_t e;
      e.kind = kind; e.done = done; e.err = err; e.acs = acs; e.sel = sel; e.t = t;
      e.tbcyc = tbcyc; e.acscyc = acscyc; e.sym = sym; e.tbrst = tbrst;
      sb_q.push_back(e);
   endtask

   function automatic logic [18:0] out_vec();
      return {bus.o_sym_ready, bus.o_en_acs, bus.o_acs_clr, bus.o_en_sel, bus.o_tb_rst_n,
              bus.o_en_t, bus.o_busy, bus.o_done, bus.o_err, bus.o_sym_cnt, bus.o_state};
   endfunction

   // Monitor: per-frame tallies, event detection and scoreboard compare.
   initial begin : monitor
      exp_rec_t e;
      logic fall, rej;
      forever begin
         @(negedge clk);
         if (post_pending) begin
            chk("post_err_low", int'(bus.o_err), 0);
            chk("post_tb_rst_n_high", int'(bus.o_tb_rst_n), 1);
            if (post_reject) chk("post_reject_busy", int'(bus.o_busy), 0);
            post_pending = 1'b0;
            post_reject  = 1'b0;
         end
         if (!prev_busy && bus.o_busy === 1'b1) begin
            m_acs = 0; m_sel = 0; m_t = 0; m_tbcyc = 0; m_acscyc = 0; m_done = 0; m_excl = 0;
         end
         if (prev_busy || bus.o_busy === 1'b1) begin
            m_acs    += int'(bus.o_en_acs);
            m_sel    += int'(bus.o_en_sel);
            m_t      += int'(bus.o_en_t);
            m_done   += int'(bus.o_done);
            m_tbcyc  += (bus.o_state == TB)  ? 1 : 0;
            m_acscyc += (bus.o_state == ACS) ? 1 : 0;
            if (int'(bus.o_en_acs) + int'(bus.o_en_sel) + int'(bus.o_en_t) > 1) m_excl++;
         end
         fall = prev_busy && (bus.o_busy === 1'b0);
         rej  = !prev_busy && (bus.o_busy === 1'b0) && (bus.o_err === 1'b1);
         if (fall || rej) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_event: got event (reject=%0d), expected none", rej);
            end else begin
               e = sb_q.pop_front();
               chk("event_kind", rej ? 1 : 0, e.kind);
               chk("end_state_idle", int'(bus.o_state), int'(IDLE));
               chk("err_at_end", int'(bus.o_err), e.err);
               if (!rej) begin
                  chk("done_pulses", m_done, e.done);
                  chk("acs_enables", m_acs, e.acs);
                  chk("sel_enables", m_sel, e.sel);
                  chk("t_enables", m_t, e.t);
                  chk("tb_cycles", m_tbcyc, e.tbcyc);
                  chk("acs_cycles", m_acscyc, e.acscyc);
                  chk("sym_cnt_at_end", int'(bus.o_sym_cnt), e.sym);
                  chk("tb_rst_n_at_end", int'(bus.o_tb_rst_n), e.tbrst);
                  chk("enable_overlap", m_excl, 0);
               end
            end
            post_pending = 1'b1;
            post_reject  = rej;
         end
         prev_busy = (bus.o_busy === 1'b1);
      end
   end

   task automatic wait_en_t(input int n);
      int seen = 0;
      int k = 0;
      while (seen < n && k < 300) begin
         @(negedge clk);
         k++;
         if (bus.o_en_t === 1'b1) seen++;
      end
      if (seen < n) bound_fail("wait_en_t");
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (bus.o_busy !== 1'b0 && k < max) begin
         @(negedge clk);
         k++;
      end
      if (bus.o_busy !== 1'b0) bound_fail("wait_idle");
   endtask

   task automatic start(input int num);
      @(negedge clk);
      bus.i_start   = 1'b1;
      bus.i_sym_num = SYM_W'(num);
      @(negedge clk);
      bus.i_start   = 1'b0;
   endtask

   // Stimulus: directed scenarios with hand-derived expectations.
   initial begin : stimulus
      int k;
      bus.i_start = 1'b0; bus.i_sym_num = '0; bus.i_sym_valid = 1'b0;
      bus.i_tb_done = 1'b0; bus.i_abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'(out_vec()), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("tb_rst_n_after_reset", int'(bus.o_tb_rst_n), 1);
      chk("idle_busy_low", int'(bus.o_busy), 0);

      // 8 symbols back-to-back, traceback done after 8 enables.
      push(0, 1, 0, 8, 1, 8, 9, 8, 8, 1);
      bus.i_sym_valid = 1'b1;
      start(8);
      wait_en_t(8);
      bus.i_tb_done = 1'b1;
      @(negedge clk);
      chk("done_after_tb_done", int'(bus.o_done), 1);
      bus.i_tb_done = 1'b0;
      wait_idle(20);
      bus.i_sym_valid = 1'b0;

      // 4 symbols, valid alternating; start re-asserted while busy is ignored.
      push(0, 1, 0, 4, 1, 2, 3, 8, 4, 1);
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_sym_num = 7'd4; bus.i_sym_valid = 1'b0;
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_sym_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.i_sym_valid = ~bus.i_sym_valid;
         bus.i_start     = 1'b1;
         bus.i_sym_num   = 7'd1;
      end
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_sym_valid = 1'b0;
      wait_en_t(2);
      bus.i_tb_done = 1'b1;
      @(negedge clk);
      bus.i_tb_done = 1'b0;
      wait_idle(20);

      // Out-of-range frame lengths.
      push(1, 0, 1, -1, -1, -1, -1, -1, -1, -1);
      start(0);
      repeat (3) @(negedge clk);
      push(1, 0, 1, -1, -1, -1, -1, -1, -1, -1);
      start(TB_DEPTH_DEF + 1);
      repeat (3) @(negedge clk);

      // Traceback never completes: watchdog fires after the allowed window.
      push(0, 0, 1, 2, 1, TB_DEPTH_DEF + WD_MARGIN_DEF, TB_DEPTH_DEF + WD_MARGIN_DEF + 1,
           2, 2, -1);
      bus.i_sym_valid = 1'b1;
      start(2);
      wait_idle(300);
      bus.i_sym_valid = 1'b0;

      // Abort in ACS after 3 accepts, then a clean 3-symbol frame.
      push(0, 0, 0, 3, 0, 0, 0, 4, 3, 0);
      bus.i_sym_valid = 1'b1;
      start(8);
      k = 0;
      while (!(bus.o_state == ACS && bus.o_sym_cnt == 7'd3) && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) bound_fail("wait_three_accepts");
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      wait_idle(20);
      push(0, 1, 0, 3, 1, 1, 2, 3, 3, 1);
      start(3);
      wait_en_t(1);
      bus.i_tb_done = 1'b1;
      @(negedge clk);
      bus.i_tb_done = 1'b0;
      wait_idle(20);

      // Abort and traceback-done together: abort wins.
      push(0, 0, 0, 1, 1, 1, 2, 1, 1, 0);
      start(1);
      wait_en_t(1);
      bus.i_abort = 1'b1; bus.i_tb_done = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0; bus.i_tb_done = 1'b0;
      wait_idle(20);

      // Synchronous reset while in traceback.
      push(0, 0, 0, 2, 1, 1, 2, 2, 0, 0);
      start(2);
      wait_en_t(1);
      rst = 1'b1; bus.i_abort = 1'b1;
      @(negedge clk);
      chk("reset_in_tb_outputs", int'(out_vec()), 0);
      rst = 1'b0; bus.i_abort = 1'b0; bus.i_sym_valid = 1'b0;
      repeat (3) @(negedge clk);

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
